// File: rtl/frame_pkg.sv
// Shared definitions for the frame controller slice: command encodings,
// FSM state encoding and the reset-view origin constants.
package frame_pkg;

    typedef enum logic [2:0] {
        OP_REDRAW     = 3'd0,
        OP_LEFT       = 3'd1,
        OP_RIGHT      = 3'd2,
        OP_UP         = 3'd3,
        OP_DOWN       = 3'd4,
        OP_ZOOM_IN    = 3'd5,
        OP_ZOOM_OUT   = 3'd6,
        OP_RESET_VIEW = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_KICK  = 3'd2,
        ST_SOLVE = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    // Reset-view origin: x = -2.0, y = -1.0 with 20 fractional bits.
    localparam int RESET_MIN_X = -(2 << 20);
    localparam int RESET_MIN_Y = -(1 << 20);

endpackage

// File: rtl/frame_controller_if.sv
// Bus between the command source / solver / iterator side and the frame
// controller.
//   cmd_valid/cmd_ready/cmd_op : command handshake
//   solver_reset/solver_done   : multi_solver restart and completion
//   readout_en/end_stream      : pixel iterator enable and completion
//   min_x/min_y/dx/dy          : current view (signed fixed point)
//   busy/frame_done/frame_count: status
// Modport slave is the controller side, master the environment side.
interface frame_controller_if #(
    parameter int WIDTH = 27
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [2:0]              cmd_op;
    logic                    solver_reset;
    logic                    solver_done;
    logic                    readout_en;
    logic                    end_stream;
    logic signed [WIDTH-1:0] min_x;
    logic signed [WIDTH-1:0] min_y;
    logic signed [WIDTH-1:0] dx;
    logic signed [WIDTH-1:0] dy;
    logic                    busy;
    logic                    frame_done;
    logic [15:0]             frame_count;

    modport slave (
        input  cmd_valid, cmd_op, solver_done, end_stream,
        output cmd_ready, solver_reset, readout_en, min_x, min_y, dx, dy,
               busy, frame_done, frame_count
    );

    modport master (
        output cmd_valid, cmd_op, solver_done, end_stream,
        input  cmd_ready, solver_reset, readout_en, min_x, min_y, dx, dy,
               busy, frame_done, frame_count
    );
endinterface

// File: rtl/frame_controller_view_update.sv
// view_update: combinational next-view computation.
//   op            : command to apply
//   min_x/min_y/d : current view origin and pixel pitch
//   nx/ny/nd      : resulting view
// All arithmetic wraps modulo 2^WIDTH; no saturation on the origin.
module view_update
    import frame_pkg::*;
#(
    parameter int NUM_COLUMNS = 99,
    parameter int NUM_ROWS    = 66,
    parameter int WIDTH       = 27,
    parameter int PAN_STEP    = 8,
    parameter int DEFAULT_D   = 31775
) (
    input  op_e                     op,
    input  logic signed [WIDTH-1:0] min_x,
    input  logic signed [WIDTH-1:0] min_y,
    input  logic signed [WIDTH-1:0] d,
    output logic signed [WIDTH-1:0] nx,
    output logic signed [WIDTH-1:0] ny,
    output logic signed [WIDTH-1:0] nd
);
    localparam logic signed [WIDTH-1:0] PAN      = WIDTH'(PAN_STEP);
    localparam logic signed [WIDTH-1:0] HALF_C   = WIDTH'(NUM_COLUMNS / 2);
    localparam logic signed [WIDTH-1:0] HALF_R   = WIDTH'(NUM_ROWS / 2);
    localparam logic signed [WIDTH-1:0] ZOOM_LIM = WIDTH'(64'sd1 << (WIDTH - 3));
    localparam logic signed [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic signed [WIDTH-1:0] RST_X    = WIDTH'(RESET_MIN_X);
    localparam logic signed [WIDTH-1:0] RST_Y    = WIDTH'(RESET_MIN_Y);
    localparam logic signed [WIDTH-1:0] RST_D    = WIDTH'(DEFAULT_D);

    logic signed [WIDTH-1:0] half_d;

    assign half_d = d >>> 1;

    always_comb begin
        nx = min_x;
        ny = min_y;
        nd = d;
        unique case (op)
            OP_LEFT:  nx = min_x - PAN * d;
            OP_RIGHT: nx = min_x + PAN * d;
            OP_UP:    ny = min_y - PAN * d;
            OP_DOWN:  ny = min_y + PAN * d;
            // Zoom about the frame centre: the centre pixel stays put.
            OP_ZOOM_IN: begin
                if (d > ONE) begin
                    nx = min_x + HALF_C * half_d;
                    ny = min_y + HALF_R * half_d;
                    nd = half_d;
                end
            end
            // Upper bound keeps the doubled pitch from reaching the sign bit.
            OP_ZOOM_OUT: begin
                if (d < ZOOM_LIM) begin
                    nx = min_x - HALF_C * d;
                    ny = min_y - HALF_R * d;
                    nd = d <<< 1;
                end
            end
            OP_RESET_VIEW: begin
                nx = RST_X;
                ny = RST_Y;
                nd = RST_D;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/frame_controller.sv
// frame_controller: sequences one render per accepted command.
//   clock, reset (synchronous, active high)
//   bus (slave): command handshake, solver restart/done, iterator
//                enable/end, current view, busy/frame_done/frame_count.
// A one-deep pending slot holds a command that arrives while a frame is
// in flight; it runs on the cycle after frame_done.
// Optional: FRAME_CONTROLLER_AUTOSTART_EN renders the reset view once
// right after reset without waiting for a command.
module frame_controller
    import frame_pkg::*;
#(
    parameter int NUM_COLUMNS = 99,
    parameter int NUM_ROWS    = 66,
    parameter int WIDTH       = 27,
    parameter int PAN_STEP    = 8,
    parameter int DEFAULT_D   = 31775
) (
    input  logic                 clock,
    input  logic                 reset,
    frame_controller_if.slave    bus
);
    state_e                  state, next_state;
    op_e                     cur_op, pending_op;
    logic                    pending_valid;
    logic signed [WIDTH-1:0] min_x, min_y, d;
    logic signed [WIDTH-1:0] nx, ny, nd;
    logic [15:0]             frame_count;
    logic                    accept;
    logic                    autostart_now;

`ifdef FRAME_CONTROLLER_AUTOSTART_EN
    logic autostart_pend;
    assign autostart_now = autostart_pend && (state == ST_IDLE);
`else
    assign autostart_now = 1'b0;
`endif

    assign bus.cmd_ready = !pending_valid;
    assign accept        = bus.cmd_valid && !pending_valid;

    view_update #(
        .NUM_COLUMNS (NUM_COLUMNS),
        .NUM_ROWS    (NUM_ROWS),
        .WIDTH       (WIDTH),
        .PAN_STEP    (PAN_STEP),
        .DEFAULT_D   (DEFAULT_D)
    ) u_view_update (
        .op    (cur_op),
        .min_x (min_x),
        .min_y (min_y),
        .d     (d),
        .nx    (nx),
        .ny    (ny),
        .nd    (nd)
    );

    // State register plus the datapath registers it sequences.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            cur_op        <= OP_REDRAW;
            pending_op    <= OP_REDRAW;
            pending_valid <= 1'b0;
            min_x         <= WIDTH'(RESET_MIN_X);
            min_y         <= WIDTH'(RESET_MIN_Y);
            d             <= WIDTH'(DEFAULT_D);
            frame_count   <= '0;
`ifdef FRAME_CONTROLLER_AUTOSTART_EN
            autostart_pend <= 1'b1;
`endif
        end else begin
            state <= next_state;
`ifdef FRAME_CONTROLLER_AUTOSTART_EN
            autostart_pend <= 1'b0;
`endif
            // In IDLE a fresh command bypasses the slot; elsewhere (and
            // during the autostart cycle) it is parked in the slot.
            if (state == ST_IDLE && !autostart_now) begin
                if (accept) begin
                    cur_op <= op_e'(bus.cmd_op);
                end else if (pending_valid) begin
                    cur_op        <= pending_op;
                    pending_valid <= 1'b0;
                end
            end else if (accept) begin
                pending_valid <= 1'b1;
                pending_op    <= op_e'(bus.cmd_op);
            end
            if (state == ST_LOAD) begin
                min_x <= nx;
                min_y <= ny;
                d     <= nd;
            end
            if (state == ST_DRAIN && bus.end_stream)
                frame_count <= frame_count + 16'd1;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (autostart_now)
                    next_state = ST_KICK;
                else if (accept || pending_valid)
                    next_state = ST_LOAD;
            end
            ST_LOAD:  next_state = ST_KICK;
            ST_KICK:  next_state = ST_SOLVE;
            ST_SOLVE: if (bus.solver_done) next_state = ST_DRAIN;
            ST_DRAIN: if (bus.end_stream)  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.solver_reset = (state == ST_KICK);
        bus.readout_en   = (state == ST_DRAIN);
        bus.busy         = (state != ST_IDLE);
        bus.frame_done   = (state == ST_DRAIN) && bus.end_stream;
    end

    assign bus.min_x       = min_x;
    assign bus.min_y       = min_y;
    assign bus.dx          = d;
    assign bus.dy          = d;
    assign bus.frame_count = frame_count;
endmodule

// File: tb/tb_frame_controller.sv
module tb_frame_controller;
    localparam int W = 27;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    frame_controller_if #(.WIDTH(W)) bus ();

    frame_controller #(
        .NUM_COLUMNS (99),
        .NUM_ROWS    (66),
        .WIDTH       (W),
        .PAN_STEP    (8),
        .DEFAULT_D   (31775)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Reference view, advanced by hand-written fixed-point rules.
    logic signed [W-1:0] ex, ey, ed;
    int                  efc;

    task automatic chk(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        ex = -27'sd2097152;
        ey = -27'sd1048576;
        ed = 27'sd31775;
    endtask

    task automatic model_apply(input logic [2:0] op);
        logic signed [W-1:0] h;
        case (op)
            3'd1: ex = ex - 27'sd8 * ed;
            3'd2: ex = ex + 27'sd8 * ed;
            3'd3: ey = ey - 27'sd8 * ed;
            3'd4: ey = ey + 27'sd8 * ed;
            3'd5: if (ed > 27'sd1) begin
                h  = ed >>> 1;
                ex = ex + 27'sd49 * h;
                ey = ey + 27'sd33 * h;
                ed = h;
            end
            3'd6: if (ed < 27'sd16777216) begin
                ex = ex - 27'sd49 * ed;
                ey = ey - 27'sd33 * ed;
                ed = ed * 27'sd2;
            end
            3'd7: model_reset();
            default: ;
        endcase
    endtask

    task automatic check_view(input string tag);
        chk({tag, "_min_x"}, bus.min_x, ex);
        chk({tag, "_min_y"}, bus.min_y, ey);
        chk({tag, "_dx"}, bus.dx, ed);
        chk({tag, "_dy"}, bus.dy, ed);
    endtask

    // Runs a frame from the KICK cycle onward.
    task automatic finish_from_kick(input string tag);
        chk({tag, "_kick"}, bus.solver_reset, 1);
        check_view(tag);
        bus.solver_done = 1'b1;          // ignored in KICK
        tick();                          // SOLVE
        bus.solver_done = 1'b0;
        chk({tag, "_kick_pulse"}, bus.solver_reset, 0);
        chk({tag, "_solve_no_rd"}, bus.readout_en, 0);
        bus.end_stream = 1'b1; #1;       // ignored in SOLVE
        chk({tag, "_solve_no_fd"}, bus.frame_done, 0);
        bus.end_stream = 1'b0;
        tick();
        chk({tag, "_still_solve"}, bus.readout_en, 0);
        bus.solver_done = 1'b1;
        tick();                          // DRAIN
        bus.solver_done = 1'b0;
        chk({tag, "_drain_rd"}, bus.readout_en, 1);
        tick();
        chk({tag, "_drain_wait"}, bus.frame_done, 0);
        bus.end_stream = 1'b1; #1;
        chk({tag, "_frame_done"}, bus.frame_done, 1);
        tick();                          // IDLE
        bus.end_stream = 1'b0;
        efc++;
        chk({tag, "_count"}, bus.frame_count, efc);
        chk({tag, "_idle"}, bus.busy, 0);
        check_view({tag, "_hold"});
    endtask

    task automatic frame(input string tag, input logic [2:0] op);
        chk({tag, "_ready"}, bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        tick();                          // LOAD
        bus.cmd_valid = 1'b0;
        chk({tag, "_load_busy"}, bus.busy, 1);
        chk({tag, "_load_no_kick"}, bus.solver_reset, 0);
        model_apply(op);
        tick();                          // KICK
        finish_from_kick(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        tick();
        tick();
        efc = 0;
        model_reset();
        check_view({tag, "_rst"});
        chk({tag, "_rst_busy"}, bus.busy, 0);
        chk({tag, "_rst_ready"}, bus.cmd_ready, 1);
        chk({tag, "_rst_count"}, bus.frame_count, 0);
        chk({tag, "_rst_kick"}, bus.solver_reset, 0);
        chk({tag, "_rst_rd"}, bus.readout_en, 0);
        chk({tag, "_rst_fd"}, bus.frame_done, 0);
        reset = 1'b0;
        tick();
`ifdef FRAME_CONTROLLER_AUTOSTART_EN
        finish_from_kick({tag, "_auto"});
`else
        chk({tag, "_no_auto"}, bus.busy, 0);
`endif
    endtask

    initial begin
        logic signed [W-1:0] sx, sy, sd;
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = 3'd0;
        bus.solver_done = 1'b0;
        bus.end_stream  = 1'b0;
        efc = 0;
        model_reset();

        do_reset("r0");

        // Pan right: hand value -2097152 + 8*31775.
        frame("right", 3'd2);
        chk("right_hand_x", bus.min_x, -1842952);

        // Zoom-in from the reset view.
        do_reset("r1");
        frame("zin", 3'd5);
        chk("zin_hand_d", bus.dx, 15887);
        chk("zin_hand_x", bus.min_x, -1318689);
        chk("zin_hand_y", bus.min_y, -524305);

        // Zoom-out from the reset view, then up to the pitch limit.
        do_reset("r2");
        frame("zout", 3'd6);
        chk("zout_hand_d", bus.dx, 63550);
        chk("zout_hand_x", bus.min_x, -3654127);
        chk("zout_hand_y", bus.min_y, -2097151);
        for (int i = 0; i < 9; i++) frame("zout_n", 3'd6);
        chk("zout_top_d", bus.dx, 32537600);
        sx = bus.min_x; sy = bus.min_y; sd = bus.dx;
        frame("zout_lim", 3'd6);
        chk("zout_lim_x", bus.min_x, sx);
        chk("zout_lim_y", bus.min_y, sy);
        chk("zout_lim_d", bus.dx, sd);

        // Zoom in down to dx=1, then once more (view must not change).
        do_reset("r3");
        for (int i = 0; i < 14; i++) frame("zin_n", 3'd5);
        chk("zin_min_d", bus.dx, 1);
        sx = bus.min_x; sy = bus.min_y;
        frame("zin_lim", 3'd5);
        chk("zin_lim_x", bus.min_x, sx);
        chk("zin_lim_y", bus.min_y, sy);
        chk("zin_lim_d", bus.dx, 1);
        chk("zin_lim_cnt", bus.frame_count, efc);

        // Other ops from the reset view.
        do_reset("r4");
        frame("up", 3'd3);
        chk("up_hand_y", bus.min_y, -1302776);
        frame("down", 3'd4);
        frame("down2", 3'd4);
        frame("left", 3'd1);
        frame("redraw", 3'd0);
        frame("rview", 3'd7);

        // Pending slot: left issued during SOLVE, third command held off.
        do_reset("r5");
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'd0;
        tick();                          // LOAD
        bus.cmd_valid = 1'b0;
        tick();                          // KICK
        tick();                          // SOLVE
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'd1;
        tick();
        chk("pend_ready_low", bus.cmd_ready, 0);
        bus.cmd_op = 3'd2;               // third command held on the bus
        bus.solver_done = 1'b1;
        tick();                          // DRAIN
        bus.solver_done = 1'b0;
        chk("pend_ready_drain", bus.cmd_ready, 0);
        bus.end_stream = 1'b1; #1;
        chk("pend_fd", bus.frame_done, 1);
        tick();                          // IDLE, slot still full
        bus.end_stream = 1'b0;
        bus.cmd_valid  = 1'b0;
        chk("pend_cnt1", bus.frame_count, 1);
        chk("pend_idle_ready", bus.cmd_ready, 0);
        chk("pend_idle_busy", bus.busy, 0);
        tick();                          // LOAD of the pending left
        chk("pend_load_busy", bus.busy, 1);
        chk("pend_load_ready", bus.cmd_ready, 1);
        efc = 1;
        model_apply(3'd1);
        tick();                          // KICK
        finish_from_kick("pend_left");
        chk("pend_hand_x", bus.min_x, -2351352);
        tick();
        chk("pend_no_third", bus.busy, 0);

        // Reset while draining, with a command parked in the slot.
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'd2;
        tick();                          // LOAD
        bus.cmd_valid = 1'b0;
        tick(); tick();                  // KICK, SOLVE
        bus.solver_done = 1'b1;
        tick();                          // DRAIN
        bus.solver_done = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'd4;
        tick();
        bus.cmd_valid = 1'b0;
        chk("drain_pend", bus.cmd_ready, 0);
        chk("drain_rd", bus.readout_en, 1);
        do_reset("r6");
        tick();
        chk("r6_pend_dropped", bus.busy, 0);
        chk("r6_pend_ready", bus.cmd_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/frame_controller.md
# frame_controller

Sequences whole-frame renders of the Mandelbrot datapath. Accepts pan/zoom/reset-view commands, maintains the current view (min_x, min_y, dx, dy in signed fixed point), restarts the multi-solver with the new view, and waits for solve completion. It then enables the pixel iterator to stream results out and signals frame completion. It sits between the user/host command source and the multi_solver / pixel_iterator pair.

## Interface
Parameters:
- NUM_COLUMNS, 99, pixels per row; HALF_COLS = NUM_COLUMNS/2 (integer division)
- NUM_ROWS, 66, rows per frame; HALF_ROWS = NUM_ROWS/2
- WIDTH, 27, coordinate width, signed two's complement, 20 fractional bits
- PAN_STEP, 8, pixels moved per pan command
- DEFAULT_D, 31775, reset-view pixel pitch

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command slot free
- cmd_op  in  3  0 redraw, 1 left, 2 right, 3 up, 4 down, 5 zoom-in, 6 zoom-out, 7 reset-view
- solver_reset  out  1  one-cycle restart pulse to multi_solver
- solver_done  in  1  all solvers finished
- readout_en  out  1  pixel iterator enable
- end_stream  in  1  iterator finished last pixel
- min_x, min_y  out  WIDTH  view origin, signed
- dx, dy  out  WIDTH  pixel pitch, signed, always equal
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse at frame end
- frame_count  out  16  completed frames, wraps 0xFFFF->0

## Operation
- States: IDLE, LOAD, KICK, SOLVE, DRAIN.
- IDLE: command handshake (cmd_valid & cmd_ready) -> LOAD; else, if pending slot full -> LOAD using pending op.
- LOAD: apply op to view registers (one cycle) -> KICK.
- KICK: solver_reset=1 -> SOLVE.
- SOLVE: wait solver_done=1 -> DRAIN.
- DRAIN: readout_en=1 until end_stream=1; that cycle -> IDLE, frame_done=1, frame_count+1.
- One-deep pending slot: cmd_ready = !pending_valid. A command accepted while in IDLE goes straight to LOAD without occupying the slot. A command accepted in any other state is latched in the slot and consumed on the cycle after frame_done.
- Arithmetic (modular WIDTH-bit, no saturation on min_x/min_y):
  - left/right: min_x -/+= PAN_STEP*dx.
  - up/down: min_y -/+= PAN_STEP*dy.
  - zoom-in: if dx>1, d'=dx>>>1, min_x += HALF_COLS*d', min_y += HALF_ROWS*d'. If dx<=1: view unchanged.
  - zoom-out: if dx < 2^(WIDTH-3), min_x -= HALF_COLS*dx, min_y -= HALF_ROWS*dx, d'=dx<<1. Otherwise view unchanged.
  - reset-view and reset: min_x=-(2<<20), min_y=-(1<<20), dx=dy=DEFAULT_D.
  - redraw: view unchanged.
- Every accepted command, including no-change cases, renders exactly one frame.

## Timing
- Reset values: state IDLE, cmd_ready=1, solver_reset=0, readout_en=0, busy=0, frame_done=0, frame_count=0, pending cleared, view = reset-view values.
- Accept at cycle N (IDLE) -> LOAD at N+1 -> view outputs updated and solver_reset=1 at N+2 -> SOLVE from N+3.
- View outputs stable from KICK through the next LOAD.
- solver_done asserted in KICK is ignored; it is sampled only in SOLVE.
- end_stream is sampled only in DRAIN.
- Simultaneous frame end and new command: the command goes to the pending slot (if free) and runs next.
- Reset mid-frame returns to IDLE and drops the pending slot; the solver is not restarted.

## Configuration
- FRAME_CONTROLLER_AUTOSTART_EN defined: the cycle after reset deasserts, the FSM enters KICK and renders the reset view once without a command.
- Not defined: remains in IDLE until the first command.

## Structure
- Package frame_pkg: cmd_op encodings, state enum, reset-view constants (-(2<<20), -(1<<20)).
- Sub-module view_update: combinational next-view computation (op, current view -> new view). The FSM registers its result in LOAD.

## Test plan
- Reset -> min_x=-2097152, min_y=-1048576, dx=dy=31775, busy=0, cmd_ready=1, frame_count=0.
- Right (op 2) at cycle N -> min_x=-1842952 and solver_reset=1 at N+2; after end_stream: frame_done pulse, frame_count=1.
- Zoom-in from reset view -> dx=dy=15887, min_x=-1318689, min_y=-524305.
- Zoom-in with dx=1 -> view unchanged, one full frame still rendered.
- Left issued during SOLVE -> cmd_ready falls. A third command is held off until the slot drains. The pending left starts LOAD the cycle after frame_done; frame_count=2 after both frames.
- Reset asserted in DRAIN -> all outputs at reset values next cycle, pending dropped. With FRAME_CONTROLLER_AUTOSTART_EN, solver_reset pulses one cycle after reset release.
